// File: rtl/addsub_nibble_seq.sv
// rtl/addsub_nibble_seq.sv - multi-cycle WIDTH-bit add/subtract, one NIB-bit nibble per cycle, LSB first
module addsub_nibble_seq #(
    parameter int WIDTH = 16,
    parameter int NIB   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int NUM_NIB = WIDTH / NIB;
    localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovfl_q, ovfl_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [NIB-1:0]   a_nib, b_nib;
    logic [NIB:0]     nsum;
    logic [WIDTH-1:0] sum_new, sum_fin;
    logic             ovfl_new;
    logic             last_nib;

    always_comb begin
        a_nib    = a_q[idx_q*NIB +: NIB];
        b_nib    = b_q[idx_q*NIB +: NIB];
        nsum     = {1'b0, a_nib} + {1'b0, b_nib} + {{NIB{1'b0}}, carry_q};
        sum_new  = sum_q;
        sum_new[idx_q*NIB +: NIB] = nsum[NIB-1:0];
        // Carry into the MSB is recovered as sum ^ a ^ b at that bit position.
        ovfl_new = nsum[NIB-1] ^ a_nib[NIB-1] ^ b_nib[NIB-1] ^ nsum[NIB];
        sum_fin  = sum_new;
        if (sat_q && ovfl_new) begin
            sum_fin = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        last_nib = (idx_q == IDX_W'(NUM_NIB - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    sat_d   = sat;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_new;
                carry_d = nsum[NIB];
                idx_d   = idx_q + IDX_W'(1);
                if (last_nib) begin
                    sum_d   = sum_fin;
                    ovfl_d  = ovfl_new;
                    zero_d  = (sum_fin == '0);
                    neg_d   = sum_fin[WIDTH-1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sat_q   <= sat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign ovfl      = ovfl_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// tb/tb_addsub_nibble_seq.sv - directed self-checking bench for addsub_nibble_seq
module tb_addsub_nibble_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        sat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        ovfl;
    logic        zero;
    logic        neg;

    int tests = 0;
    int fails = 0;

    addsub_nibble_seq #(.WIDTH(16), .NIB(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovfl      (ovfl),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, check latency and results; optionally complete the out handshake.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tsub, input logic tsat, input logic [15:0] exp_sum,
                          input logic exp_ovfl, input logic do_release);
        int cnt;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; sub = tsub; sat = tsat; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 32'd4);
        chk({tag, "_sum"},  {16'd0, sum}, {16'd0, exp_sum});
        chk({tag, "_ovfl"}, {31'd0, ovfl}, {31'd0, exp_ovfl});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_sum == 16'h0000)});
        chk({tag, "_neg"},  {31'd0, neg},  {31'd0, exp_sum[15]});
        if (do_release) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
        end
    endtask

    initial begin
        #2;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, sum},       32'd0);
        chk("rst_flags",     {29'd0, ovfl, zero, neg}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("c1",     16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b1);
        run_op("c2_raw", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op("c2_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("c3_z",   16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_op("c3_n",   16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b1);
        run_op("c4_pos", 16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("c4_neg", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
        run_op("c4_raw", 16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);

        // Backpressure in DONE while new operands are offered
        run_op("c5_a", 16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("c5_hold_sum", {16'd0, sum}, 32'h2221);
            chk("c5_hold_hs",  {29'd0, out_valid, in_ready, ovfl}, 32'd4);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("c5_idle", {30'd0, in_ready, out_valid}, 32'd2);
        run_op("c5_b", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b1);

        // Reset after two nibbles of a carry-rippling op
        a = 16'hFFFF; b = 16'h0001; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("c6_rst_hs",  {30'd0, in_ready, out_valid}, 32'd2);
        chk("c6_rst_sum", {16'd0, sum}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("c6_after", 16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
